// File: rtl/lif_post_neuron.sv
// Leaky integrate-and-fire postsynaptic neuron with five programmable 8-bit
// synaptic weights, saturating membrane and a fixed-length refractory period.
module lif_post_neuron #(
    parameter logic [9:0] THRESHOLD     = 10'd200,
    parameter logic [9:0] LEAK          = 10'd1,
    parameter logic [3:0] REFRAC_CYCLES = 4'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] pre_spike,
    input  logic       w_load,
    input  logic [2:0] w_sel,
    input  logic [7:0] w_data,
    output logic       post_spike,
    output logic [9:0] membrane,
    output logic       refractory,
    output logic [7:0] spike_count
);

    typedef enum logic {INTEGRATE, REFRACTORY} state_t;

    state_t          state, state_next;
    logic [4:0][7:0] w;
    logic [3:0]      refrac_cnt;
    logic [10:0]     sum;
    logic [9:0]      leaked;
    logic [11:0]     total;
    logic [9:0]      v_next;
    logic            fire;

    // Weights read here are the pre-edge values, so a same-cycle write
    // only takes effect on the following cycle.
    always_comb begin
        sum = '0;
        for (int i = 0; i < 5; i++)
            sum = sum + (pre_spike[i] ? {3'b000, w[i]} : 11'd0);
        leaked = (membrane >= LEAK) ? membrane - LEAK : 10'd0;
        total  = {2'b00, leaked} + {1'b0, sum};
        v_next = (total > 12'd1023) ? 10'd1023 : total[9:0];
        fire   = (v_next >= THRESHOLD);
    end

    always_comb begin
        state_next = state;
        case (state)
            INTEGRATE:  if (fire) state_next = REFRACTORY;
            REFRACTORY: if (refrac_cnt == 4'd1) state_next = INTEGRATE;
            default:    state_next = INTEGRATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= INTEGRATE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w           <= '0;
            membrane    <= '0;
            post_spike  <= 1'b0;
            spike_count <= '0;
            refrac_cnt  <= '0;
        end else begin
            for (int i = 0; i < 5; i++)
                if (w_load && w_sel == 3'(i)) w[i] <= w_data;
            post_spike <= 1'b0;
            if (state == INTEGRATE) begin
                if (fire) begin
                    membrane    <= '0;
                    post_spike  <= 1'b1;
                    spike_count <= spike_count + 8'd1;
                    refrac_cnt  <= REFRAC_CYCLES;
                end else begin
                    membrane <= v_next;
                end
            end else begin
                membrane   <= '0;
                refrac_cnt <= refrac_cnt - 4'd1;
            end
        end
    end

    assign refractory = (state == REFRACTORY);

endmodule

// File: tb/tb_lif_post_neuron.sv
// Directed, table-driven bench for lif_post_neuron: a default-parameter
// instance plus a THRESHOLD=1023 instance for saturation.
module tb_lif_post_neuron;

    logic       clk = 1'b0;
    logic       rst, w_load, post_spike, refractory;
    logic [4:0] pre_spike;
    logic [2:0] w_sel;
    logic [7:0] w_data, spike_count;
    logic [9:0] membrane;

    logic       s_rst, s_w_load, s_post_spike, s_refractory;
    logic [4:0] s_pre_spike;
    logic [2:0] s_w_sel;
    logic [7:0] s_w_data, s_spike_count;
    logic [9:0] s_membrane;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_post_neuron dut (
        .clk(clk), .rst(rst), .pre_spike(pre_spike), .w_load(w_load),
        .w_sel(w_sel), .w_data(w_data), .post_spike(post_spike),
        .membrane(membrane), .refractory(refractory), .spike_count(spike_count)
    );

    lif_post_neuron #(.THRESHOLD(10'd1023)) sat (
        .clk(clk), .rst(s_rst), .pre_spike(s_pre_spike), .w_load(s_w_load),
        .w_sel(s_w_sel), .w_data(s_w_data), .post_spike(s_post_spike),
        .membrane(s_membrane), .refractory(s_refractory), .spike_count(s_spike_count)
    );

    typedef struct {
        logic       rst;
        logic [4:0] pre;
        logic       wl;
        logic [2:0] ws;
        logic [7:0] wd;
        logic [9:0] mem;
        logic       post;
        logic       refr;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [4:0] p, input logic wl,
                       input logic [2:0] ws, input logic [7:0] wd,
                       input logic [9:0] m, input logic po, input logic rf,
                       input logic [7:0] c);
        vec_t v;
        v.rst = r; v.pre = p; v.wl = wl; v.ws = ws; v.wd = wd;
        v.mem = m; v.post = po; v.refr = rf; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic step(input logic r, input logic [4:0] p, input logic wl,
                        input logic [2:0] ws, input logic [7:0] wd);
        rst = r; pre_spike = p; w_load = wl; w_sel = ws; w_data = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic s_step(input logic r, input logic [4:0] p, input logic wl,
                          input logic [2:0] ws, input logic [7:0] wd);
        s_rst = r; s_pre_spike = p; s_w_load = wl; s_w_sel = ws; s_w_data = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fires;
        int last;
        step(1'b1, 5'd0, 1'b0, 3'd0, 8'd0);
        s_step(1'b1, 5'd0, 1'b0, 3'd0, 8'd0);

        // Reset with noisy inputs: writes and spikes must be swallowed
        for (int i = 0; i < 2; i++)
            step(1'b1, 5'($urandom), 1'b1, 3'($urandom_range(0, 4)), 8'($urandom_range(1, 255)));
        chk("rst_mem", membrane, 0);
        chk("rst_post", post_spike, 0);
        chk("rst_ref", refractory, 0);
        chk("rst_cnt", spike_count, 0);

        //   rst  pre       wl ws    wd      mem  po rf cnt
        add(0, 5'b11111, 0, 3'd0, 8'd0,    0,   0, 0, 0);  // weights zeroed by reset
        add(0, 5'b00000, 1, 3'd0, 8'd100,  0,   0, 0, 0);
        add(0, 5'b00001, 0, 3'd0, 8'd0,    100, 0, 0, 0);
        add(0, 5'b00001, 0, 3'd0, 8'd0,    199, 0, 0, 0);
        add(0, 5'b00001, 0, 3'd0, 8'd0,    0,   1, 1, 1);  // 298 >= 200 fires
        add(0, 5'b11111, 0, 3'd0, 8'd0,    0,   0, 1, 1);
        add(0, 5'b11111, 1, 3'd1, 8'd20,   0,   0, 1, 1);  // write during refractory
        add(0, 5'b11111, 0, 3'd0, 8'd0,    0,   0, 1, 1);
        add(0, 5'b11111, 0, 3'd0, 8'd0,    0,   0, 0, 1);
        add(0, 5'b11111, 0, 3'd0, 8'd0,    120, 0, 0, 1);  // 100 + 20
        add(0, 5'b00000, 0, 3'd0, 8'd0,    119, 0, 0, 1);
        add(0, 5'b00000, 1, 3'd0, 8'd50,   118, 0, 0, 1);
        add(0, 5'b00001, 1, 3'd0, 8'd200,  167, 0, 0, 1);  // collision: old 50 used
        add(0, 5'b00000, 1, 3'd6, 8'd255,  166, 0, 0, 1);  // ignored write
        add(0, 5'b00001, 0, 3'd0, 8'd0,    0,   1, 1, 2);  // 165 + 200 fires
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 1, 2);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 1, 2);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 1, 2);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 0, 2);
        add(0, 5'b11110, 0, 3'd0, 8'd0,    20,  0, 0, 2);  // w2..w4 still 0
        add(0, 5'b00000, 0, 3'd0, 8'd0,    19,  0, 0, 2);
        add(1, 5'b11111, 1, 3'd1, 8'd9,    0,   0, 0, 0);
        add(0, 5'b00000, 1, 3'd2, 8'd3,    0,   0, 0, 0);
        add(0, 5'b00100, 0, 3'd0, 8'd0,    3,   0, 0, 0);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    2,   0, 0, 0);  // leak floors at 0
        add(0, 5'b00000, 0, 3'd0, 8'd0,    1,   0, 0, 0);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 0, 0);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 0, 0);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 0, 0);
        add(0, 5'b00000, 0, 3'd0, 8'd0,    0,   0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].pre, vecs[i].wl, vecs[i].ws, vecs[i].wd);
            chk($sformatf("v%0d_mem", i),  membrane,    vecs[i].mem);
            chk($sformatf("v%0d_post", i), post_spike,  vecs[i].post);
            chk($sformatf("v%0d_ref", i),  refractory,  vecs[i].refr);
            chk($sformatf("v%0d_cnt", i),  spike_count, vecs[i].cnt);
        end

        // Saturation at 1023 with THRESHOLD=1023
        s_step(1'b0, 5'd0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 5; i++) s_step(1'b0, 5'd0, 1'b1, 3'(i), 8'd100);
        s_step(1'b0, 5'b11111, 1'b0, 3'd0, 8'd0);
        chk("sat_500", s_membrane, 500);
        s_step(1'b0, 5'b11111, 1'b0, 3'd0, 8'd0);
        chk("sat_999", s_membrane, 999);
        s_step(1'b0, 5'b11111, 1'b0, 3'd0, 8'd0);
        chk("sat_fire_mem", s_membrane, 0);
        chk("sat_fire_post", s_post_spike, 1);
        chk("sat_fire_cnt", s_spike_count, 1);

        // Reset in the middle of refractory returns straight to INTEGRATE
        step(1'b1, 5'd0, 1'b0, 3'd0, 8'd0);
        step(1'b0, 5'd0, 1'b1, 3'd0, 8'd255);
        step(1'b0, 5'b00001, 1'b0, 3'd0, 8'd0);
        chk("mid_fire", post_spike, 1);
        step(1'b0, 5'b00001, 1'b0, 3'd0, 8'd0);
        chk("mid_ref", refractory, 1);
        step(1'b1, 5'b00001, 1'b1, 3'd0, 8'd255);
        chk("mid_rst_ref", refractory, 0);
        chk("mid_rst_cnt", spike_count, 0);
        step(1'b0, 5'd0, 1'b1, 3'd0, 8'd255);
        chk("mid_int_ref", refractory, 0);
        step(1'b0, 5'b00001, 1'b0, 3'd0, 8'd0);
        chk("mid_resume", post_spike, 1);

        // Continuous drive: spacing between pulses and counter wrap
        step(1'b1, 5'd0, 1'b0, 3'd0, 8'd0);
        step(1'b0, 5'd0, 1'b1, 3'd0, 8'd255);
        fires = 0;
        last  = -100;
        for (int cyc = 0; cyc < 1500 && fires < 256; cyc++) begin
            step(1'b0, 5'b00001, 1'b0, 3'd0, 8'd0);
            if (post_spike) begin
                if (fires > 0) chk("gap", int'(cyc - last >= 5), 1);
                fires++;
                last = cyc;
                chk("cnt_track", spike_count, fires & 255);
            end
        end
        chk("fires_reached", fires, 256);
        chk("cnt_wrap", spike_count, 0);
        step(1'b0, 5'b00001, 1'b0, 3'd0, 8'd0);
        chk("pulse_one_cycle", post_spike, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
